// File: rtl/fpu_div_scheduler.sv
// fpu_div_scheduler: arbitrates two requesters onto one shared combinational FP32 divider.
// An accepted operation is held on div_a/div_b for WAIT_CYCLES cycles. The quotient is then
// captured and presented on the rsp_* interface until rsp_ready accepts it.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   reqN_valid/a/b/ready    requester N (N = 0, 1) operation handshake
//   div_a, div_b            operands to the shared divider
//   div_result              combinational quotient from the divider
//   rsp_valid/data/id/dz    response; rsp_dz flags a +/-0 divisor
//   rsp_ready               response consumer accepts
//   busy                    high whenever an operation is in flight
module fpu_div_scheduler #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_dz,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_id_q, last_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_dz_q, rsp_dz_d;

  logic gnt_valid;
  logic gnt_id;
  logic handshake;

  // On contention the requester not granted last wins; otherwise the lone valid one.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = (req0_valid & req1_valid) ? ~last_id_q : req1_valid;
  end

  // rst_n gates ready so no handshake can be reported while reset is applied.
  assign req0_ready = rst_n & (state_q == StIdle) & gnt_valid & ~gnt_id;
  assign req1_ready = rst_n & (state_q == StIdle) & gnt_valid & gnt_id;
  assign handshake  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    last_id_d  = last_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_dz_d   = rsp_dz_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          op_a_d    = gnt_id ? req1_a : req0_a;
          op_b_d    = gnt_id ? req1_b : req0_b;
          rsp_id_d  = gnt_id;
          last_id_d = gnt_id;
          cnt_d     = 4'(WAIT_CYCLES);
          state_d   = StWait;
        end
      end
      StWait: begin
        // Last settle cycle: the divider output is stable, capture it.
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          rsp_data_d = div_result;
          rsp_dz_d   = (op_b_q[30:0] == 31'd0);
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      cnt_q      <= 4'd0;
      last_id_q  <= 1'b1;
      rsp_data_q <= 32'd0;
      rsp_id_q   <= 1'b0;
      rsp_dz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      last_id_q  <= last_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_dz_q   <= rsp_dz_d;
    end
  end

  assign div_a     = op_a_q;
  assign div_b     = op_b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_dz    = rsp_dz_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_div_scheduler.sv
// Directed bench for fpu_div_scheduler with WAIT_CYCLES = 1. The shared divider is a
// lookup model holding hand-computed quotients, with an arbitrary mix for other operands.
module tb_fpu_div_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [31:0] div_a, div_b, div_result;
  logic        rsp_valid, rsp_id, rsp_dz, rsp_ready, busy;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_div_scheduler #(.WAIT_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_dz     (rsp_dz),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;  // 1 / 1
    if (a == 32'h3F800000 && b == 32'h3FC00000) return 32'h3F2AAAAB;  // 1 / 1.5
    if (a == 32'hBFA00000 && b == 32'h3FC00000) return 32'hBF555555;  // -1.25 / 1.5
    if (a == 32'h42FE1000 && b == 32'h41878000) return 32'h40F00000;  // 127.03125 / 16.9375
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h3FC00000;  // 3 / 2
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  always_comb div_result = golden(div_a, div_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    n_checks++; if (div_a !== 32'd0 || div_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_div_ops got %h/%h exp 0/0", div_a, div_b); end
    n_checks++; if (rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_dz !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp got %h/%b/%b exp 0/0/0", rsp_data, rsp_id, rsp_dz); end
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b exp 0", busy); end
  endtask

  // Both requesters valid continuously from the first cycle after reset.
  task automatic test_contention();
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3FC00000;
    req1_valid = 1'b1; req1_a = 32'hBFA00000; req1_b = 32'h3FC00000;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL cont_first_grant got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    n_checks++; if (busy !== 1'b1 || div_a !== 32'h3F800000) begin
      n_fail++; $display("FAIL cont_wait0 got busy=%b div_a=%h exp 1/3f800000", busy, div_a); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h3F2AAAAB) begin
      n_fail++; $display("FAIL cont_rsp0 got %b/%b/%h exp 1/0/3f2aaaab", rsp_valid, rsp_id, rsp_data); end
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL cont_ready_in_resp got %b%b exp 00", req0_ready, req1_ready); end
    tick();
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL cont_second_grant got %b%b exp 01", req0_ready, req1_ready); end
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'hBF555555) begin
      n_fail++; $display("FAIL cont_rsp1 got %b/%b/%h exp 1/1/bf555555", rsp_valid, rsp_id, rsp_data); end
    tick();
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL cont_third_grant got %b%b exp 10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_drop_busy got %b exp 0", busy); end
  endtask

  task automatic test_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_data, input logic exp_dz, input string nm);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n_checks++; if (req0_ready !== !id || req1_ready !== id) begin
      n_fail++; $display("FAIL %s_ready got %b%b exp id=%b", nm, req0_ready, req1_ready, id); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || div_a !== a || div_b !== b) begin
      n_fail++; $display("FAIL %s_wait got busy=%b rv=%b %h/%h exp 1/0 %h/%h",
                         nm, busy, rsp_valid, div_a, div_b, a, b); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_dz !== exp_dz) begin
      n_fail++; $display("FAIL %s_rsp got rv=%b id=%b dz=%b exp 1/%b/%b",
                         nm, rsp_valid, rsp_id, rsp_dz, id, exp_dz); end
    n_checks++; if (rsp_data !== exp_data) begin
      n_fail++; $display("FAIL %s_data got %h exp %h", nm, rsp_data, exp_data); end
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle got busy=%b rv=%b exp 0/0", nm, busy, rsp_valid); end
  endtask

  task automatic test_drop_valid();
    req1_valid = 1'b1; req1_a = 32'h11111111; req1_b = 32'h22222222;
    #1;
    req1_valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || div_a === 32'h11111111) begin
      n_fail++; $display("FAIL drop_valid got busy=%b div_a=%h exp 0", busy, div_a); end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h40000000;
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_a = 32'hAAAA0000; req0_b = 32'h0000BBBB;
    req1_valid = 1'b1; req1_a = 32'hCCCC0000; req1_b = 32'h0000DDDD;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h3FC00000 || rsp_id !== 1'b0 ||
                      rsp_dz !== 1'b0) begin
        n_fail++; $display("FAIL stall_rsp[%0d] got %b/%h/%b/%b exp 1/3fc00000/0/0",
                           i, rsp_valid, rsp_data, rsp_id, rsp_dz); end
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1 ||
                      div_a !== 32'h40400000) begin
        n_fail++; $display("FAIL stall_ctl[%0d] got rdy=%b%b busy=%b div_a=%h exp 00/1/40400000",
                           i, req0_ready, req1_ready, busy, div_a); end
      tick();
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got busy=%b rv=%b exp 0/0", busy, rsp_valid); end
  endtask

  task automatic test_reset_in_wait();
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_entry got busy=%b exp 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || div_b !== 32'd0) begin
      n_fail++; $display("FAIL rst_wait_abort got busy=%b rv=%b div_b=%h exp 0/0/0",
                         busy, rsp_valid, div_b); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_rsp got %b exp 0", rsp_valid); end
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_a = 32'h42FE1000; req1_b = 32'h41878000;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_grant got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h3F800000) begin
      n_fail++; $display("FAIL rst_wait_rsp got %b/%b/%h exp 1/0/3f800000", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single(1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "basic");
    test_single(1'b1, 32'h42FE1000, 32'h41878000, 32'h40F00000, 1'b0, "req1_only");
    test_single(1'b0, 32'h3F800000, 32'h80000000, golden(32'h3F800000, 32'h80000000), 1'b1, "dz_neg0");
    test_single(1'b0, 32'h3F800000, 32'h00000001, golden(32'h3F800000, 32'h00000001), 1'b0, "dz_denorm");
    test_drop_valid();
    test_stall();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_div_scheduler.md
FPU_DIV_SCHEDULER -- requirements
Module: fpu_div_scheduler

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, number of cycles the shared combinational FP32 divider is given to settle; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 dividend and divisor, IEEE-754 single.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006, for requester 1.
REQ-008 div_a, div_b  output  32 each  operands driven to the shared divider.
REQ-009 div_result  input  32  quotient returned by the shared divider (combinational).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_data  output  32  captured quotient.
REQ-012 rsp_id  output  1  requester owning the response.
REQ-013 rsp_dz  output  1  divisor was +0 or -0.
REQ-014 rsp_ready  input  1  response consumer accepts.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; IDLE->WAIT on a request handshake, WAIT->RESP when the settle counter expires, RESP->IDLE on rsp_valid&rsp_ready.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready high per cycle; handshake is reqN_valid&reqN_ready.
REQ-018 Grant SHALL be combinational: only one valid -> that requester; both valid -> the requester not granted last (last_id register).
REQ-019 On handshake at edge k: op_a/op_b SHALL register the granted operands, rsp_id the granted index, last_id the granted index, counter load WAIT_CYCLES.
REQ-020 div_a/div_b SHALL be driven directly from op_a/op_b and hold their values until the next handshake.
REQ-021 In WAIT the counter SHALL decrement each edge; at edge k+WAIT_CYCLES rsp_data SHALL capture div_result unmodified, rsp_dz SHALL capture (op_b[30:0]==0), and the FSM SHALL enter RESP.
REQ-022 rsp_valid SHALL be high exactly while in RESP; rsp_data/rsp_id/rsp_dz SHALL stay stable until acceptance.
REQ-023 Latency: rsp_valid first high in the cycle after edge k+WAIT_CYCLES; with rsp_ready tied high, minimum issue interval is WAIT_CYCLES+2 cycles.
REQ-024 A response accepted at an edge SHALL return the FSM to IDLE; no new grant in that same cycle (ready is low in RESP).
REQ-025 reqN_valid dropped before handshake SHALL have no effect; valid held while not ready SHALL not be lost.
REQ-026 Both requesters continuously valid SHALL be served strictly alternately 0,1,0,1...
REQ-027 Request inputs changing during WAIT/RESP SHALL not affect div_a/div_b or the pending response.
REQ-028 The block SHALL contain no arithmetic beyond the counter and the zero-divisor compare; quotient NaN/Inf handling belongs to the divider.

Reset
REQ-029 rst_n low at an edge SHALL force: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_dz 0, op_a/op_b (div_a/div_b) 0, counter 0, last_id 1 (requester 0 wins the first contention).
REQ-030 req0_ready and req1_ready SHALL be low while rst_n is low.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the operation; the aborted response SHALL never appear on rsp_valid.

Verification
REQ-032 WAIT_CYCLES=1, req0 A=0x3F800000 B=0x3F800000, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_data=0x3F800000, rsp_id=0, rsp_dz=0.
REQ-033 Both valid same cycle after reset: req0 A=0x3F800000 B=0x3FC00000, req1 A=0xBFA00000 B=0x3FC00000 -> req0 served first (~0.66667), then req1 (~-0.83333); rsp_data equal to divider golden model for each.
REQ-034 req1 only, A=0x42FE1000 B=0x41878000 -> rsp_data=0x40F00000 (7.5), rsp_id=1.
REQ-035 B=0x80000000 from req0 -> rsp_dz=1; B=0x00000001 -> rsp_dz=0.
REQ-036 rsp_ready low 5 cycles in RESP -> rsp_* stable, both ready low, busy=1; raise rsp_ready -> IDLE next cycle.
REQ-037 rst_n low for 1 cycle during WAIT -> next cycle busy=0, rsp_valid=0; subsequent simultaneous requests grant req0 first.
